// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control FSM and its condition evaluator.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH      = 4'd0,
    ST_DECODE     = 4'd1,
    ST_EXEC_R     = 4'd2,
    ST_EXEC_I     = 4'd3,
    ST_ALU_WB     = 4'd4,
    ST_LOAD_RD    = 4'd5,
    ST_LOAD_LATCH = 4'd6,
    ST_LOAD_WB    = 4'd7,
    ST_STORE_WR   = 4'd8,
    ST_BRANCH     = 4'd9,
    ST_JCOND      = 4'd10,
    ST_JAL        = 4'd11
  } state_e;

  localparam logic [3:0] OP_RTYPE   = 4'b0000;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_NOP     = 4'b1111;
  localparam logic [3:0] OP_CMPI    = 4'b1011;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_CMP   = 4'b1011;

  localparam int unsigned PSR_C = 0;
  localparam int unsigned PSR_L = 2;
  localparam int unsigned PSR_F = 5;
  localparam int unsigned PSR_Z = 6;
  localparam int unsigned PSR_N = 7;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_HI = 4'h4;
  localparam logic [3:0] CC_LS = 4'h5;
  localparam logic [3:0] CC_GT = 4'h6;
  localparam logic [3:0] CC_LE = 4'h7;
  localparam logic [3:0] CC_FS = 4'h8;
  localparam logic [3:0] CC_FC = 4'h9;
  localparam logic [3:0] CC_LO = 4'hA;
  localparam logic [3:0] CC_HS = 4'hB;
  localparam logic [3:0] CC_LT = 4'hC;
  localparam logic [3:0] CC_GE = 4'hD;
  localparam logic [3:0] CC_UC = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  localparam logic [1:0] PCSRC_INC  = 2'b00;
  localparam logic [1:0] PCSRC_REG  = 2'b01;
  localparam logic [1:0] PCSRC_DISP = 2'b10;

endpackage

// File: rtl/cond_eval.sv
// Branch/jump condition evaluator; shared by the BRANCH and JCOND states.
module cond_eval
  import mc_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [7:0] psr_i,
  output logic       taken_o
);

  logic c, l, f, z, n;
  logic unused_psr;

  assign c = psr_i[PSR_C];
  assign l = psr_i[PSR_L];
  assign f = psr_i[PSR_F];
  assign z = psr_i[PSR_Z];
  assign n = psr_i[PSR_N];
  assign unused_psr = ^{psr_i[4:3], psr_i[1]};

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      CC_EQ: taken_o = z;
      CC_NE: taken_o = !z;
      CC_CS: taken_o = c;
      CC_CC: taken_o = !c;
      CC_HI: taken_o = l;
      CC_LS: taken_o = !l;
      CC_GT: taken_o = n;
      CC_LE: taken_o = !n;
      CC_FS: taken_o = f;
      CC_FC: taken_o = !f;
      CC_LO: taken_o = !l && !z;
      CC_HS: taken_o = l || z;
      CC_LT: taken_o = !n && !z;
      CC_GE: taken_o = n || z;
      CC_UC: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the 16-bit datapath: fetch/decode/execute/memory/writeback
// sequencing with a memReady handshake guarded by a wait-cycle timeout.
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic [7:0]  capturedPSR,
  input  logic        memReady,
  output logic        pcEn,
  output logic        instrWrite,
  output logic        regWrite,
  output logic        writeBackSelect,
  output logic        dataToWriteSelect,
  output logic        newAluInput,
  output logic        psrRegEn,
  output logic        sendPcAddr,
  output logic [1:0]  aluSrc1Select,
  output logic [1:0]  aluSrc2Select,
  output logic [1:0]  pcSrc,
  output logic        memRead,
  output logic        memWrite,
  output logic        busErr,
  output logic [3:0]  state
);

  // Timeout fires on the wait cycle that would bring the counter to TIMEOUT.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       bus_err_q, bus_err_d;
  logic       taken, waiting, timeout;
  logic [3:0] op, ext;
  logic       unused_instr;

  assign op           = instr[15:12];
  assign ext          = instr[7:4];
  assign unused_instr = ^instr[3:0];

  cond_eval u_cond_eval (
    .cond_i  (instr[11:8]),
    .psr_i   (capturedPSR),
    .taken_o (taken)
  );

  assign waiting = (state_q == ST_FETCH) || (state_q == ST_LOAD_RD) || (state_q == ST_STORE_WR);
  assign timeout = waiting && !memReady && (wait_q == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      wait_q    <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = (waiting && !memReady && !timeout) ? wait_q + 8'd1 : 8'd0;
    bus_err_d = bus_err_q | timeout;
    case (state_q)
      ST_FETCH: if (memReady) state_d = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_RTYPE: state_d = ST_EXEC_R;
          OP_SPECIAL: begin
            case (ext)
              EXT_LOAD:  state_d = ST_LOAD_RD;
              EXT_STOR:  state_d = ST_STORE_WR;
              EXT_JAL:   state_d = ST_JAL;
              EXT_JCOND: state_d = ST_JCOND;
              default:   state_d = ST_FETCH;
            endcase
          end
          OP_BCOND: state_d = ST_BRANCH;
          OP_NOP:   state_d = ST_FETCH;
          default:  state_d = ST_EXEC_I;
        endcase
      end
      ST_EXEC_R:     state_d = (ext == EXT_CMP) ? ST_FETCH : ST_ALU_WB;
      ST_EXEC_I:     state_d = (op == OP_CMPI) ? ST_FETCH : ST_ALU_WB;
      ST_LOAD_RD: begin
        if (memReady)     state_d = ST_LOAD_LATCH;
        else if (timeout) state_d = ST_FETCH;
      end
      ST_LOAD_LATCH: state_d = ST_LOAD_WB;
      ST_STORE_WR:   if (memReady || timeout) state_d = ST_FETCH;
      default:       state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    pcEn              = 1'b0;
    instrWrite        = 1'b0;
    regWrite          = 1'b0;
    writeBackSelect   = 1'b0;
    dataToWriteSelect = 1'b0;
    newAluInput       = 1'b0;
    psrRegEn          = 1'b0;
    sendPcAddr        = 1'b0;
    aluSrc1Select     = 2'b00;
    aluSrc2Select     = 2'b00;
    pcSrc             = PCSRC_INC;
    memRead           = 1'b0;
    memWrite          = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          sendPcAddr = 1'b1;
          memRead    = 1'b1;
          instrWrite = memReady;
          pcEn       = memReady;
        end
        ST_DECODE: newAluInput = 1'b1;
        ST_EXEC_R, ST_EXEC_I: begin
          aluSrc1Select = 2'b01;
          aluSrc2Select = (state_q == ST_EXEC_I) ? 2'b01 : 2'b00;
          psrRegEn      = 1'b1;
        end
        ST_ALU_WB, ST_LOAD_WB: regWrite = 1'b1;
        ST_LOAD_RD: begin
          memRead         = 1'b1;
          writeBackSelect = 1'b1;
        end
        ST_LOAD_LATCH: writeBackSelect = 1'b1;
        ST_STORE_WR:   memWrite = 1'b1;
        ST_BRANCH: begin
          pcEn  = taken;
          pcSrc = taken ? PCSRC_DISP : PCSRC_INC;
        end
        ST_JCOND: begin
          pcEn  = taken;
          pcSrc = taken ? PCSRC_REG : PCSRC_INC;
        end
        ST_JAL: begin
          // Link and jump share one edge, so the jump reads Rtarget before the link lands.
          regWrite          = 1'b1;
          dataToWriteSelect = 1'b1;
          pcEn              = 1'b1;
          pcSrc             = PCSRC_REG;
        end
        default: ;
      endcase
    end
  end

  assign state  = reset ? 4'd0 : state_q;
  assign busErr = bus_err_q & ~reset;

endmodule
